lsu_lsq_issue_ctrl: RTL
=======================

Name: lsu_lsq_issue_ctrl

Overview:
- Control end of the LSQ entry array. Allocates entries at the tail, selects the oldest ready entry and issues it to the dcache request port, and routes dcache responses back as succ/replay pulses. Dequeues completed entries in order from the head.
- Sits between the LSQ entry array and the dcache/ROB side of lsuv1. Reads per-entry status vectors and drives per-entry one-hot control strobes.

Parameters:
- LSQ_DEPTH, 8, number of LSQ entries; power of two, at least 2.
- LSQ_PTR_W, 3, $clog2(LSQ_DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; same priority as rst for pointers and state
- enq_vld_i  in  1  enqueue request
- enq_rdy_o  out  1  an entry is free
- enq_alloc_o  out  LSQ_DEPTH  one-hot entry init strobe (drives the entry vld_i input)
- enq_ptr_o  out  LSQ_PTR_W  current tail index
- ent_vld_i / ent_virt_i / ent_awake_i / ent_exec_i / ent_succ_i / ent_exc_i / ent_fenced_i  in  LSQ_DEPTH each  per-entry status bits
- ent_exec_o  out  LSQ_DEPTH  one-hot issue strobe
- ent_replay_o  out  LSQ_DEPTH  one-hot replay strobe
- ent_succ_o  out  LSQ_DEPTH  one-hot success strobe
- ent_invld_o  out  LSQ_DEPTH  one-hot dequeue strobe
- issue_vld_o  out  1  dcache request valid
- issue_rdy_i  in  1  dcache request ready
- issue_idx_o  out  LSQ_PTR_W  entry index of the request
- resp_vld_i  in  1  dcache response valid
- resp_replay_i  in  1  response requests replay (miss or conflict)
- lsq_empty_o  out  1  count == 0
- lsq_full_o  out  1  count == LSQ_DEPTH

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- State: head, tail (LSQ_PTR_W bits, wrapping modulo LSQ_DEPTH), count (LSQ_PTR_W+1 bits), FSM {IDLE, WAIT, DRAIN}.
- Reset values: head=tail=count=0, FSM=IDLE. All strobes 0, issue_vld_o=0, enq_rdy_o=1, lsq_empty_o=1, lsq_full_o=0.
- Enqueue:
  - enq_rdy_o = ~lsq_full_o. There is no full-bypass, so a dequeue in the same cycle does not free a slot early.
  - On enq_vld_i & enq_rdy_o: enq_alloc_o[tail]=1 in the same cycle (combinational), and tail increments at the edge.
- Eligibility, for entry i: vld & ~virt & awake & ~exec & ~succ & ~exc & (~fenced | i==head).
- Selection: the oldest eligible entry, scanning from head toward tail (rotate-priority). Entries outside [head, tail) are never selected.
- FSM IDLE:
  - issue_vld_o = any eligible; issue_idx_o = the selected entry.
  - On issue_vld_o & issue_rdy_i: ent_exec_o[sel]=1 in the same cycle, latch sel into out_idx, go to WAIT.
- FSM WAIT:
  - issue_vld_o=0.
  - On resp_vld_i: if resp_replay_i, ent_replay_o[out_idx]=1; else ent_succ_o[out_idx]=1. Go to IDLE.
  - Issue resumes in the cycle after the response (one outstanding request max).
- FSM DRAIN: issue_vld_o=0. On resp_vld_i the response is dropped with no strobes, and the FSM goes to IDLE.
- Dequeue:
  - If count>0 & ent_vld_i[head] & (ent_succ_i[head] | ent_exc_i[head]): ent_invld_o[head]=1 and head increments.
  - At most one dequeue per cycle.
  - Exception entries dequeue without ever issuing.
- Count: count_next = count + enq_fire − deq_fire. Simultaneous enqueue and dequeue leaves count unchanged.
- Flush (and rst):
  - head, tail and count go to 0. Strobes are suppressed in the flush cycle.
  - FSM goes to DRAIN if it was in WAIT and resp_vld_i is not asserted in that cycle; otherwise it goes to IDLE.
- A resp_vld_i arriving in IDLE is ignored. The ent_* inputs are not re-checked while in WAIT.

Optional Feature:
- Macro: LSU_LSQ_ISSUE_PERF_CNT_EN.
- Defined: adds three outputs, each 32 bits, saturating, cleared by rst only (not by flush):
  - perf_issue_cnt_o counts issue fires.
  - perf_replay_cnt_o counts replay responses.
  - perf_full_stall_cnt_o counts cycles with enq_vld_i & lsq_full_o.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package / params.vh: LSQ_DEPTH, LSQ_PTR_W, and the FSM state encoding localparams (IDLE=2'd0, WAIT=2'd1, DRAIN=2'd2).
- One natural sub-module: lsu_lsq_age_pick. It is a combinational rotate-from-head oldest-first picker: inputs are the eligibility vector and head; outputs are found and idx.

Test Plan:
- Enqueue 8 with no dequeue (LSQ_DEPTH=8). Required: tail wraps to 0, lsq_full_o=1, enq_rdy_o=0. A 9th enq_vld_i produces no enq_alloc_o.
- Entries 2 and 5 awake, head=1, issue_rdy_i=1. Required: issue_idx_o=2 with ent_exec_o=8'b0000_0100. Next cycle WAIT, so issue_vld_o=0.
- In WAIT, resp_vld_i=1 with resp_replay_i=1. Required: ent_replay_o[2]=1 and FSM returns to IDLE. With ent_exec_i[2] then cleared, entry 2 reissues.
- Head=3 has ent_exc_i=1 and was never issued. Required: ent_invld_o=8'b0000_1000 in that cycle; head becomes 4 and count decrements by 1.
- Flush asserted in WAIT with no response in the flush cycle. Required: FSM enters DRAIN. A response arriving 3 cycles later produces no succ/replay strobe, and FSM returns to IDLE.
- Entry at index 4 is fenced and awake while head=2. Required: not issued. Once head=4 after two dequeues, it issues with issue_idx_o=4.

Source files
------------

// File: rtl/lsu_lsq_issue_ctrl_pkg.sv
// Shared LSQ issue-control constants and FSM state encoding.
package lsu_lsq_issue_ctrl_pkg;
  localparam int LSQ_DEPTH = 8;
  localparam int LSQ_PTR_W = $clog2(LSQ_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } lsq_iss_state_e;
endpackage

// File: rtl/lsu_lsq_issue_ctrl_age_pick.sv
// Combinational oldest-first picker: scans the eligibility vector starting at head.
module lsu_lsq_age_pick #(
  parameter int LSQ_DEPTH = lsu_lsq_issue_ctrl_pkg::LSQ_DEPTH,
  parameter int LSQ_PTR_W = lsu_lsq_issue_ctrl_pkg::LSQ_PTR_W
) (
  input  logic [LSQ_DEPTH-1:0] elig_i,
  input  logic [LSQ_PTR_W-1:0] head_i,
  output logic                 found_o,
  output logic [LSQ_PTR_W-1:0] idx_o
);
  logic [LSQ_PTR_W-1:0] cand;

  // Walk from youngest offset to oldest so the last hit (smallest offset) wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = LSQ_DEPTH - 1; k >= 0; k--) begin
      cand = head_i + LSQ_PTR_W'(k);
      if (elig_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end
endmodule

// File: rtl/lsu_lsq_issue_ctrl.sv
// LSQ control: tail allocation, oldest-ready issue to dcache, response routing, in-order dequeue.
// Optional perf counters enabled by defining LSU_LSQ_ISSUE_PERF_CNT_EN.
module lsu_lsq_issue_ctrl #(
  parameter int LSQ_DEPTH = lsu_lsq_issue_ctrl_pkg::LSQ_DEPTH,
  parameter int LSQ_PTR_W = lsu_lsq_issue_ctrl_pkg::LSQ_PTR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 enq_vld_i,
  output logic                 enq_rdy_o,
  output logic [LSQ_DEPTH-1:0] enq_alloc_o,
  output logic [LSQ_PTR_W-1:0] enq_ptr_o,
  input  logic [LSQ_DEPTH-1:0] ent_vld_i,
  input  logic [LSQ_DEPTH-1:0] ent_virt_i,
  input  logic [LSQ_DEPTH-1:0] ent_awake_i,
  input  logic [LSQ_DEPTH-1:0] ent_exec_i,
  input  logic [LSQ_DEPTH-1:0] ent_succ_i,
  input  logic [LSQ_DEPTH-1:0] ent_exc_i,
  input  logic [LSQ_DEPTH-1:0] ent_fenced_i,
  output logic [LSQ_DEPTH-1:0] ent_exec_o,
  output logic [LSQ_DEPTH-1:0] ent_replay_o,
  output logic [LSQ_DEPTH-1:0] ent_succ_o,
  output logic [LSQ_DEPTH-1:0] ent_invld_o,
  output logic                 issue_vld_o,
  input  logic                 issue_rdy_i,
  output logic [LSQ_PTR_W-1:0] issue_idx_o,
  input  logic                 resp_vld_i,
  input  logic                 resp_replay_i,
`ifdef LSU_LSQ_ISSUE_PERF_CNT_EN
  output logic [31:0]          perf_issue_cnt_o,
  output logic [31:0]          perf_replay_cnt_o,
  output logic [31:0]          perf_full_stall_cnt_o,
`endif
  output logic                 lsq_empty_o,
  output logic                 lsq_full_o
);
  import lsu_lsq_issue_ctrl_pkg::*;

  lsq_iss_state_e       state_q, state_d;
  logic [LSQ_PTR_W-1:0] head_q, head_d, tail_q, tail_d, out_idx_q, out_idx_d;
  logic [LSQ_PTR_W:0]   count_q, count_d;
  logic [LSQ_DEPTH-1:0] in_rng, elig;
  logic                 clr, enq_fire, deq_fire, issue_fire, resp_succ, resp_rply;
  logic                 pick_found;
  logic [LSQ_PTR_W-1:0] pick_idx;

  assign clr         = rst | flush;
  assign lsq_empty_o = (count_q == '0);
  assign lsq_full_o  = (count_q == (LSQ_PTR_W + 1)'(LSQ_DEPTH));
  assign enq_rdy_o   = ~lsq_full_o;
  assign enq_ptr_o   = tail_q;
  assign enq_fire    = enq_vld_i & enq_rdy_o & ~clr;
  assign deq_fire    = ~lsq_empty_o & ent_vld_i[head_q]
                     & (ent_succ_i[head_q] | ent_exc_i[head_q]) & ~clr;

  // An entry is a candidate only if its offset from head lies inside the occupied window.
  always_comb begin
    in_rng = '0;
    elig   = '0;
    for (int i = 0; i < LSQ_DEPTH; i++) begin
      in_rng[i] = {1'b0, LSQ_PTR_W'(i) - head_q} < count_q;
      elig[i]   = in_rng[i] & ent_vld_i[i] & ~ent_virt_i[i] & ent_awake_i[i]
                & ~ent_exec_i[i] & ~ent_succ_i[i] & ~ent_exc_i[i]
                & (~ent_fenced_i[i] | (LSQ_PTR_W'(i) == head_q));
    end
  end

  lsu_lsq_age_pick #(
    .LSQ_DEPTH (LSQ_DEPTH),
    .LSQ_PTR_W (LSQ_PTR_W)
  ) u_age_pick (
    .elig_i  (elig),
    .head_i  (head_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    out_idx_d   = out_idx_q;
    issue_vld_o = 1'b0;
    issue_fire  = 1'b0;
    resp_succ   = 1'b0;
    resp_rply   = 1'b0;
    case (state_q)
      IDLE: begin
        issue_vld_o = pick_found & ~clr;
        if (issue_vld_o & issue_rdy_i) begin
          issue_fire = 1'b1;
          out_idx_d  = pick_idx;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (resp_vld_i) begin
          resp_rply = resp_replay_i & ~clr;
          resp_succ = ~resp_replay_i & ~clr;
          state_d   = IDLE;
        end
      end
      DRAIN: begin
        if (resp_vld_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A flushed request still owes a response unless it arrives this very cycle.
    if (flush) state_d = (state_q == WAIT && !resp_vld_i) ? DRAIN : IDLE;
  end

  assign issue_idx_o  = pick_idx;
  assign enq_alloc_o  = enq_fire   ? (LSQ_DEPTH'(1) << tail_q)    : '0;
  assign ent_exec_o   = issue_fire ? (LSQ_DEPTH'(1) << pick_idx)  : '0;
  assign ent_replay_o = resp_rply  ? (LSQ_DEPTH'(1) << out_idx_q) : '0;
  assign ent_succ_o   = resp_succ  ? (LSQ_DEPTH'(1) << out_idx_q) : '0;
  assign ent_invld_o  = deq_fire   ? (LSQ_DEPTH'(1) << head_q)    : '0;

  assign head_d  = head_q + LSQ_PTR_W'(deq_fire);
  assign tail_d  = tail_q + LSQ_PTR_W'(enq_fire);
  assign count_d = count_q + (LSQ_PTR_W + 1)'(enq_fire) - (LSQ_PTR_W + 1)'(deq_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
    if (clr) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
    out_idx_q <= out_idx_d;
  end

`ifdef LSU_LSQ_ISSUE_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  logic [31:0] perf_issue_q, perf_replay_q, perf_stall_q;

  // Perf counters survive flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_q  <= '0;
      perf_replay_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issue_q  <= sat_inc(perf_issue_q, issue_fire);
      perf_replay_q <= sat_inc(perf_replay_q, resp_rply);
      perf_stall_q  <= sat_inc(perf_stall_q, enq_vld_i & lsq_full_o);
    end
  end

  assign perf_issue_cnt_o      = perf_issue_q;
  assign perf_replay_cnt_o     = perf_replay_q;
  assign perf_full_stall_cnt_o = perf_stall_q;
`endif
endmodule
